// File: rtl/gmii_tx_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : gmii_tx_pkg
// Brief  : Shared constants and state encoding for the GMII TX framer.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package gmii_tx_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PAD_BYTE      = 8'h00;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SFD  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_PAD  = 3'd4;
  localparam logic [2:0] ST_DROP = 3'd5;
  localparam logic [2:0] ST_IFG  = 3'd6;

  localparam int CNT_W  = 16;
  localparam int BCNT_W = 11;

  typedef logic [CNT_W-1:0] cnt_t;
  // One extra bit so byte_cnt+1 never wraps before comparison.
  typedef logic [BCNT_W:0]  bcnt_ext_t;

endpackage
`default_nettype wire

// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : gmii_tx_framer
// Brief  : Wraps a valid/ready byte stream in preamble+SFD on GMII, pads short
//          frames, truncates long ones and enforces the inter-frame gap.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module gmii_tx_framer
  import gmii_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int MAX_PAYLOAD  = 1514,
  parameter int IFG_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic        ppt2gtc_gmii_dv,
  output logic        ppt2gtc_gmii_er,
  output logic [7:0]  ppt2gtc_gmii_data,
  output logic [15:0] tx_frame_cnt,
  output logic [15:0] tx_err_cnt
);

  // The IDLE->PRE transition already loads the first preamble byte.
  localparam cnt_t      PRE_LOAD = cnt_t'(PREAMBLE_LEN - 2);
  localparam cnt_t      IFG_LOAD = cnt_t'(IFG_CYCLES - 1);
  localparam bcnt_ext_t MIN_CNT  = bcnt_ext_t'(MIN_PAYLOAD);
  localparam bcnt_ext_t MAX_CNT  = bcnt_ext_t'(MAX_PAYLOAD);

  logic [2:0]        state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              err_q, err_d;
  logic              dv_q, dv_d;
  logic              er_q, er_d;
  logic [7:0]        data_q, data_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  bcnt_ext_t         byte_cnt_inc;
  logic              count_frame;

  assign byte_cnt_inc = {1'b0, byte_cnt_q} + bcnt_ext_t'(1);

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE:          in_ready = in_valid & ~in_sop;
      ST_DATA, ST_DROP: in_ready = 1'b1;
      default:          in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    err_d       = err_q;
    dv_d        = 1'b0;
    er_d        = 1'b0;
    data_d      = PAD_BYTE;
    count_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_sop) begin
          state_d    = ST_PRE;
          cnt_d      = PRE_LOAD;
          byte_cnt_d = '0;
          err_d      = 1'b0;
          dv_d       = 1'b1;
          data_d     = PREAMBLE_BYTE;
        end
      end
      ST_PRE: begin
        dv_d   = 1'b1;
        data_d = PREAMBLE_BYTE;
        if (cnt_q == '0) state_d = ST_SFD;
        else             cnt_d   = cnt_q - cnt_t'(1);
      end
      ST_SFD: begin
        dv_d    = 1'b1;
        data_d  = SFD_BYTE;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        dv_d       = 1'b1;
        byte_cnt_d = byte_cnt_inc[BCNT_W-1:0];
        if (in_valid) begin
          data_d = in_data;
          // The sop byte itself is payload byte 0; any later sop is a protocol error.
          if (in_sop && (byte_cnt_q != '0)) err_d = 1'b1;
        end else begin
          er_d  = 1'b1;
          err_d = 1'b1;
        end
        if (in_valid && in_eop) begin
          if (byte_cnt_inc < MIN_CNT) begin
            state_d = ST_PAD;
          end else begin
            state_d     = ST_IFG;
            cnt_d       = IFG_LOAD;
            count_frame = 1'b1;
          end
        end else if (byte_cnt_inc == MAX_CNT) begin
          er_d    = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DROP;
          cnt_d   = IFG_LOAD;
        end
      end
      ST_PAD: begin
        dv_d       = 1'b1;
        byte_cnt_d = byte_cnt_inc[BCNT_W-1:0];
        if (byte_cnt_inc == MIN_CNT) begin
          state_d     = ST_IFG;
          cnt_d       = IFG_LOAD;
          count_frame = 1'b1;
        end
      end
      ST_DROP: begin
        // Gap timer already runs here; it saturates so IFG lasts at least one cycle.
        if (cnt_q != '0) cnt_d = cnt_q - cnt_t'(1);
        if (in_valid && in_eop) begin
          state_d     = ST_IFG;
          count_frame = 1'b1;
        end
      end
      ST_IFG: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - cnt_t'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    frame_cnt_d = count_frame ? frame_cnt_q + 16'd1 : frame_cnt_q;
    err_cnt_d   = (count_frame && err_d) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      byte_cnt_q  <= '0;
      err_q       <= 1'b0;
      dv_q        <= 1'b0;
      er_q        <= 1'b0;
      data_q      <= 8'h00;
      frame_cnt_q <= 16'h0000;
      err_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      err_q       <= err_d;
      dv_q        <= dv_d;
      er_q        <= er_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign ppt2gtc_gmii_dv   = dv_q;
  assign ppt2gtc_gmii_er   = er_q;
  assign ppt2gtc_gmii_data = data_q;
  assign tx_frame_cnt      = frame_cnt_q;
  assign tx_err_cnt        = err_cnt_q;

endmodule
`default_nettype wire
